// File: rtl/vigna_mem_resp.sv
// vigna_mem_resp: word-addressed memory with fetch (i) and data (d) request/response ports
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   i_valid/i_addr        fetch request and byte address
//   i_ready/i_rdata       one-cycle response pulse and fetched word
//   d_valid/d_addr        data request and byte address
//   d_wdata/d_wstrb       store data and byte strobes (0 = read)
//   d_ready/d_rdata       one-cycle response pulse and load word
// Parameters: MEM_WORDS (power of two), WAIT_CYCLES (0-15) between acceptance and ready.
// Macro VIGNA_MEM_RESP_DUAL_PORT_EN: independent i/d array ports; undefined gives a
// single-port array where only one port is busy at a time and d wins ties.
module vigna_mem_resp #(
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         i_st, d_st;
    logic [3:0]     i_cnt, d_cnt;
    logic [AW-1:0]  i_idx, d_idx;
    logic [31:0]    d_wd;
    logic [3:0]     d_ws;
    logic [31:0]    mem [MEM_WORDS];

    logic           i_grant, d_grant, i_acc, d_acc, i_go, d_go;
    logic [AW-1:0]  i_sel, d_sel;
    logic [31:0]    d_wsel;
    logic [3:0]     d_ssel;
    logic           unused;

    assign unused = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

`ifdef VIGNA_MEM_RESP_DUAL_PORT_EN
    assign d_grant = 1'b1;
    assign i_grant = 1'b1;
`else
    // Shared array: a port may start only when both FSMs are idle, and d has priority.
    assign d_grant = (i_st == IDLE) && (d_st == IDLE);
    assign i_grant = d_grant && !d_valid;
`endif

    assign i_acc = (i_st == IDLE) && i_valid && i_grant;
    assign d_acc = (d_st == IDLE) && d_valid && d_grant;

    // Edge entering RESP: straight from IDLE when there is no wait, else the last WAIT cycle.
    assign i_go = (i_acc && WC == 4'd0) || (i_st == WAIT && i_cnt == 4'd1);
    assign d_go = (d_acc && WC == 4'd0) || (d_st == WAIT && d_cnt == 4'd1);

    // In IDLE the request has not been captured yet, so use the live inputs.
    assign i_sel  = (i_st == IDLE) ? i_addr[AW+1:2] : i_idx;
    assign d_sel  = (d_st == IDLE) ? d_addr[AW+1:2] : d_idx;
    assign d_wsel = (d_st == IDLE) ? d_wdata : d_wd;
    assign d_ssel = (d_st == IDLE) ? d_wstrb : d_ws;

    always_ff @(posedge clk) begin
        if (reset) begin
            i_st    <= IDLE;
            i_cnt   <= '0;
            i_idx   <= '0;
            i_ready <= 1'b0;
            i_rdata <= '0;
        end else begin
            i_ready <= i_go;
            if (i_go)
                i_rdata <= mem[i_sel];
            case (i_st)
                IDLE: if (i_acc) begin
                    i_idx <= i_addr[AW+1:2];
                    i_cnt <= WC;
                    i_st  <= (WC == 4'd0) ? RESP : WAIT;
                end
                WAIT: begin
                    i_cnt <= i_cnt - 4'd1;
                    if (i_cnt == 4'd1)
                        i_st <= RESP;
                end
                default: i_st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_st    <= IDLE;
            d_cnt   <= '0;
            d_idx   <= '0;
            d_wd    <= '0;
            d_ws    <= '0;
            d_ready <= 1'b0;
            d_rdata <= '0;
        end else begin
            d_ready <= d_go;
            if (d_go && d_ssel == 4'd0)
                d_rdata <= mem[d_sel];
            case (d_st)
                IDLE: if (d_acc) begin
                    d_idx <= d_addr[AW+1:2];
                    d_wd  <= d_wdata;
                    d_ws  <= d_wstrb;
                    d_cnt <= WC;
                    d_st  <= (WC == 4'd0) ? RESP : WAIT;
                end
                WAIT: begin
                    d_cnt <= d_cnt - 4'd1;
                    if (d_cnt == 4'd1)
                        d_st <= RESP;
                end
                default: d_st <= IDLE;
            endcase
        end
    end

    // Array is never reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && d_go) begin
            for (int b = 0; b < 4; b++)
                if (d_ssel[b])
                    mem[d_sel][8*b +: 8] <= d_wsel[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_vigna_mem_resp.sv
// tb_vigna_mem_resp: randomized self-checking bench for vigna_mem_resp against a word-array model
module tb_vigna_mem_resp;
    localparam int MW = 16;
    localparam int W  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0, d_valid = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        i_ready, d_ready;
    logic [31:0] i_rdata, d_rdata;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model [MW];

    always #5 clk = ~clk;

    vigna_mem_resp #(.MEM_WORDS(MW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb)
    );

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % MW);
    endfunction

    task automatic i_txn(input logic [31:0] a, output logic [31:0] rd, output int lat, output int pulses);
        i_addr = a;
        i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        lat = -1; pulses = 0; rd = 'x;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (i_ready) begin
                pulses++;
                if (lat < 0) begin lat = k; rd = i_rdata; end
            end
        end
    endtask

    task automatic d_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         output logic [31:0] rd, output int lat, output int pulses);
        d_addr = a; d_wdata = wd; d_wstrb = ws;
        d_valid = 1'b1;
        @(posedge clk);
        #1 d_valid = 1'b0;
        lat = -1; pulses = 0; rd = 'x;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (d_ready) begin
                pulses++;
                if (lat < 0) begin lat = k; rd = d_rdata; end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i_ready got %b want 0", i_ready); end
        n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready got %b want 0", d_ready); end
        n_checks++; if (i_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_i_rdata got %h want 0", i_rdata); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
    endtask

    task automatic test_fill_and_read();
        logic [31:0] v, rd, a;
        int lat, p, j;
        for (int i = 0; i < MW; i++) begin
            v = $urandom;
            d_txn(32'(i * 4), v, 4'hf, rd, lat, p);
            model[i] = v;
            n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL fill_latency got %0d want %0d", lat, W + 1); end
            n_checks++; if (p !== 1) begin n_fail++; $display("FAIL fill_pulses got %0d want 1", p); end
        end
        for (int n = 0; n < 16; n++) begin
            a = $urandom;
            j = widx(a);
            i_txn(a, rd, lat, p);
            n_checks++; if (rd !== model[j] || lat !== W + 1 || p !== 1)
                begin n_fail++; $display("FAIL i_read got %h lat %0d pulses %0d want %h lat %0d pulses 1", rd, lat, p, model[j], W + 1); end
        end
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            j = widx(a);
            d_txn(a, $urandom, 4'h0, rd, lat, p);
            n_checks++; if (rd !== model[j] || lat !== W + 1 || p !== 1)
                begin n_fail++; $display("FAIL d_read got %h lat %0d pulses %0d want %h lat %0d pulses 1", rd, lat, p, model[j], W + 1); end
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd, prev, a, wd;
        logic [3:0]  ws;
        int lat, p, j;
        d_txn(32'h8, 32'h11223344, 4'hf, rd, lat, p);
        model[2] = 32'h11223344;
        d_txn(32'h14, 32'h0, 4'h0, rd, lat, p);
        prev = d_rdata;
        n_checks++; if (prev !== model[5]) begin n_fail++; $display("FAIL preload_read got %h want %h", prev, model[5]); end
        d_txn(32'h8, 32'hAABBCCDD, 4'b0011, rd, lat, p);
        model[2] = 32'h1122CCDD;
        n_checks++; if (p !== 1) begin n_fail++; $display("FAIL byte_write_pulses got %0d want 1", p); end
        n_checks++; if (d_rdata !== prev) begin n_fail++; $display("FAIL byte_write_rdata got %h want %h", d_rdata, prev); end
        i_txn(32'h8, rd, lat, p);
        n_checks++; if (rd !== 32'h1122CCDD) begin n_fail++; $display("FAIL byte_write_mem got %h want 1122ccdd", rd); end
        for (int n = 0; n < 20; n++) begin
            a = $urandom; wd = $urandom; ws = 4'($urandom_range(1, 15));
            j = widx(a);
            prev = d_rdata;
            d_txn(a, wd, ws, rd, lat, p);
            for (int b = 0; b < 4; b++)
                if (ws[b]) model[j][8*b +: 8] = wd[8*b +: 8];
            n_checks++; if (d_rdata !== prev || p !== 1)
                begin n_fail++; $display("FAIL strobe_write rdata %h pulses %0d want %h pulses 1", d_rdata, p, prev); end
            i_txn({$urandom_range(0, 255), 20'h0, 4'(j), 2'($urandom_range(0, 3))}, rd, lat, p);
            n_checks++; if (rd !== model[j]) begin n_fail++; $display("FAIL strobe_readback got %h want %h", rd, model[j]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, a;
        int lat, p;
        d_txn(32'h0, 32'h5A5AC3C3, 4'hf, rd, lat, p);
        model[0] = 32'h5A5AC3C3;
        i_txn(32'h40, rd, lat, p);
        n_checks++; if (rd !== model[0]) begin n_fail++; $display("FAIL wrap_0x40 got %h want %h", rd, model[0]); end
        for (int n = 0; n < 6; n++) begin
            a = {$urandom_range(1, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 63));
            d_txn(a, 32'h0, 4'h0, rd, lat, p);
            n_checks++; if (rd !== model[widx(a)]) begin n_fail++; $display("FAIL wrap_rand got %h want %h", rd, model[widx(a)]); end
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] ia, da, ir, dr;
        int ik, dk, ip, dp, ik_exp;
`ifdef VIGNA_MEM_RESP_DUAL_PORT_EN
        ik_exp = W + 1;
`else
        ik_exp = 2 * W + 3;
`endif
        for (int n = 0; n < 3; n++) begin
            ia = $urandom; da = $urandom;
            i_addr = ia; d_addr = da; d_wstrb = 4'h0;
            i_valid = 1'b1; d_valid = 1'b1;
            @(posedge clk);
            #1 d_valid = 1'b0;
            ik = -1; dk = -1; ip = 0; dp = 0; ir = 'x; dr = 'x;
            for (int k = 1; k <= 2 * W + 6; k++) begin
                @(negedge clk);
                if (d_ready) begin dp++; if (dk < 0) begin dk = k; dr = d_rdata; end end
                if (i_ready) begin ip++; if (ik < 0) begin ik = k; ir = i_rdata; end i_valid = 1'b0; end
            end
            i_valid = 1'b0;
            repeat (W + 3) @(negedge clk);
            n_checks++; if (dk !== W + 1 || dp !== 1) begin n_fail++; $display("FAIL arb_d_ready at %0d pulses %0d want %0d pulses 1", dk, dp, W + 1); end
            n_checks++; if (ik !== ik_exp || ip !== 1) begin n_fail++; $display("FAIL arb_i_ready at %0d pulses %0d want %0d pulses 1", ik, ip, ik_exp); end
            n_checks++; if (dr !== model[widx(da)]) begin n_fail++; $display("FAIL arb_d_data got %h want %h", dr, model[widx(da)]); end
            n_checks++; if (ir !== model[widx(ia)]) begin n_fail++; $display("FAIL arb_i_data got %h want %h", ir, model[widx(ia)]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        int kk [4];
        logic [31:0] dd [4];
        int n;
        for (int m = 0; m < 4; m++) begin a[m] = $urandom; kk[m] = -1; dd[m] = 'x; end
        i_addr = a[0];
        i_valid = 1'b1;
        n = 0;
        for (int k = 1; k <= 4 * (W + 2) + 4; k++) begin
            @(negedge clk);
            if (i_ready && n < 4) begin
                kk[n] = k; dd[n] = i_rdata; n++;
                if (n < 4) i_addr = a[n]; else i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        repeat (W + 3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            n_checks++; if (kk[m] !== W + 1 + m * (W + 2) || dd[m] !== model[widx(a[m])])
                begin n_fail++; $display("FAIL b2b_%0d ready at %0d data %h want %0d data %h", m, kk[m], dd[m], W + 1 + m * (W + 2), model[widx(a[m])]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, p, pulses;
        d_txn(32'h1C, 32'h12345678, 4'hf, rd, lat, p);
        model[7] = 32'h12345678;
        d_txn(32'h1C, 32'h0, 4'h0, rd, lat, p);
        i_txn(32'h1C, rd, lat, p);
        d_addr = 32'h1C; d_wdata = 32'hEDCBA987; d_wstrb = 4'hf;
        d_valid = 1'b1;
        @(posedge clk);
        #1 d_valid = 1'b0;
        pulses = 0;
        @(negedge clk);
        if (d_ready) pulses++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if (d_ready) pulses++;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (d_ready) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_pulses got %0d want 0", pulses); end
        n_checks++; if (d_rdata !== 32'h0 || i_rdata !== 32'h0)
            begin n_fail++; $display("FAIL rst_mid_rdata got d %h i %h want 0 0", d_rdata, i_rdata); end
        i_txn(32'h1C, rd, lat, p);
        n_checks++; if (rd !== model[7]) begin n_fail++; $display("FAIL rst_mid_mem got %h want %h", rd, model[7]); end
    endtask

    initial begin
        test_reset();
        test_fill_and_read();
        test_byte_write();
        test_wrap();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
